// File: rtl/pifo_trace_pkg.sv
// pifo_trace_pkg: shared widths, pop_data field slices and error bit indices for the PIFO pop-order monitor.
package pifo_trace_pkg;
    localparam int PTW      = 16;
    localparam int TREE_NUM = 4;
    localparam int TNB      = $clog2(TREE_NUM);
    localparam int MTW      = TNB;
    localparam int CTW      = 16;
    localparam int OUTSTAND = 8;
    localparam int TIMEOUT  = 64;
    localparam int PRIO_LSB = 0;
    localparam int META_LSB = PRIO_LSB + PTW;
    typedef enum logic [1:0] {ERR_ORDER, ERR_UNDERFLOW, ERR_TAG, ERR_TIMEOUT} err_e;
endpackage

// File: rtl/pop_ts_fifo.sv
// pop_ts_fifo: register FIFO of pop-request timestamps; head is read combinationally, same-cycle push+pop allowed.
module pop_ts_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign head  = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/pop_order_checker.sv
// pop_order_checker: passive monitor of the push/pop stream; flags PIFO order, underflow, tag and latency
// violations per tree and keeps traffic counters, per-tree occupancy and worst-case pop latency.
module pop_order_checker
    import pifo_trace_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_push,
    input  logic [TNB-1:0]     i_push_tree_id,
    input  logic [PTW-1:0]     i_push_priority,
    input  logic               i_pop,
    input  logic               i_pop_out,
    input  logic [TNB-1:0]     i_pop_tree_id,
    input  logic [MTW+PTW-1:0] i_pop_data,
    input  logic [TNB-1:0]     i_stat_tree_id,
    output logic [CTW-1:0]     o_push_cnt,
    output logic [CTW-1:0]     o_pop_cnt,
    output logic [CTW-1:0]     o_occupancy,
    output logic [CTW-1:0]     o_max_latency,
    output logic [3:0]         o_err,
    output logic [TNB-1:0]     o_err_tree_id
);
    logic [CTW-1:0] ts, head, age;
    logic full, empty, fifo_push, fifo_pop;
    logic [TREE_NUM-1:0][CTW-1:0] occ, occ_n;
    logic [TREE_NUM-1:0][PTW-1:0] floor_q, floor_n;
    logic [TREE_NUM-1:0] vld, vld_n, hit_push, hit_pop;
    logic [TNB-1:0] t, m;
    logic [PTW-1:0] p;
    logic tag_e, under_e, order_e, pop_ok, ovf_e, tmo_e;
    logic [3:0] new_err;

    assign t = i_pop_tree_id;
    assign p = i_pop_data[PRIO_LSB +: PTW];
    assign m = i_pop_data[META_LSB +: MTW];
    assign age = ts - head;
    assign fifo_pop  = i_pop_out && !empty;
    // a full FIFO still accepts a request when the head leaves in the same cycle
    assign fifo_push = i_pop && (!full || fifo_pop);
    assign ovf_e     = i_pop && full && !fifo_pop;
    assign tmo_e     = !empty && age > CTW'(TIMEOUT);
    assign tag_e     = i_pop_out && m != t;
    assign under_e   = i_pop_out && (occ[t] == '0 || empty);
    assign order_e   = i_pop_out && vld[t] && p < floor_q[t];
    assign pop_ok    = i_pop_out && !tag_e && !under_e && !order_e;
    assign o_occupancy = occ[i_stat_tree_id];

    pop_ts_fifo #(.DEPTH(OUTSTAND), .W(CTW)) u_fifo (
        .clk(i_clk), .rst_n(i_arst_n), .push(fifo_push), .pop(fifo_pop),
        .din(ts), .head(head), .full(full), .empty(empty)
    );

    for (genvar g = 0; g < TREE_NUM; g++) begin : g_hit
        assign hit_push[g] = i_push && i_push_tree_id == TNB'(g);
        assign hit_pop[g]  = pop_ok && t == TNB'(g);
    end

    always_comb begin
        new_err = '0;
        new_err[ERR_ORDER]     = order_e;
        new_err[ERR_UNDERFLOW] = under_e;
        new_err[ERR_TAG]       = tag_e;
        new_err[ERR_TIMEOUT]   = ovf_e || tmo_e;
    end

    // a concurrent push on the popped tree may lower the new floor below the popped priority
    always_comb begin
        occ_n   = occ;
        floor_n = floor_q;
        vld_n   = vld;
        for (int k = 0; k < TREE_NUM; k++) begin
            if (hit_push[k] && !hit_pop[k]) occ_n[k] = (&occ[k]) ? occ[k] : occ[k] + 1'b1;
            else if (hit_pop[k] && !hit_push[k]) occ_n[k] = occ[k] - 1'b1;
            if (hit_pop[k]) begin
                floor_n[k] = (hit_push[k] && i_push_priority < p) ? i_push_priority : p;
                vld_n[k]   = 1'b1;
            end else if (hit_push[k] && vld[k] && i_push_priority < floor_q[k]) begin
                floor_n[k] = i_push_priority;
            end
            if (occ_n[k] == '0) vld_n[k] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            ts            <= '0;
            occ           <= '0;
            floor_q       <= '0;
            vld           <= '0;
            o_push_cnt    <= '0;
            o_pop_cnt     <= '0;
            o_max_latency <= '0;
            o_err         <= '0;
            o_err_tree_id <= '0;
        end else begin
            ts      <= ts + 1'b1;
            occ     <= occ_n;
            floor_q <= floor_n;
            vld     <= vld_n;
            if (i_push && !(&o_push_cnt)) o_push_cnt <= o_push_cnt + 1'b1;
            if (i_pop_out && !(&o_pop_cnt)) o_pop_cnt <= o_pop_cnt + 1'b1;
            if (fifo_pop && age > o_max_latency) o_max_latency <= age;
            o_err <= o_err | new_err;
            if (o_err == '0 && new_err != '0)
                o_err_tree_id <= (new_err[ERR_TAG] || new_err[ERR_UNDERFLOW] || new_err[ERR_ORDER]) ? t : i_push_tree_id;
        end
endmodule

// File: tb/tb_pop_order_checker.sv
// tb_pop_order_checker: directed table of single-cycle vectors plus hand-written multi-cycle corner sequences.
module tb_pop_order_checker;
    logic        clk = 0;
    logic        arst_n = 0;
    logic        push = 0, pop = 0, pop_out = 0;
    logic [1:0]  push_tree = 0, pop_tree = 0, stat_tree = 0;
    logic [15:0] push_prio = 0;
    logic [17:0] pop_data = 0;
    logic [15:0] push_cnt, pop_cnt, occupancy, max_latency;
    logic [3:0]  err;
    logic [1:0]  err_tree;
    int n_chk = 0, n_fail = 0;

    pop_order_checker dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_push(push), .i_push_tree_id(push_tree),
        .i_push_priority(push_prio), .i_pop(pop), .i_pop_out(pop_out), .i_pop_tree_id(pop_tree),
        .i_pop_data(pop_data), .i_stat_tree_id(stat_tree), .o_push_cnt(push_cnt), .o_pop_cnt(pop_cnt),
        .o_occupancy(occupancy), .o_max_latency(max_latency), .o_err(err), .o_err_tree_id(err_tree)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [1:0]  ptree;
        logic [15:0] pprio;
        logic        pop, pout;
        logic [1:0]  otree, ometa;
        logic [15:0] oprio;
        logic [1:0]  stree;
        logic [3:0]  e_err;
        logic [15:0] e_occ, e_pc, e_qc, e_lat;
    } vec_t;
    vec_t tbl [33];

    function automatic vec_t mk(input logic pu, input logic [1:0] pt, input logic [15:0] pp,
                                input logic po, input logic ou, input logic [1:0] ot, input logic [1:0] om,
                                input logic [15:0] op, input logic [1:0] st, input logic [3:0] ee,
                                input logic [15:0] eo, input logic [15:0] epc, input logic [15:0] eqc,
                                input logic [15:0] el);
        vec_t v;
        v.push = pu; v.ptree = pt; v.pprio = pp; v.pop = po; v.pout = ou; v.otree = ot; v.ometa = om;
        v.oprio = op; v.stree = st; v.e_err = ee; v.e_occ = eo; v.e_pc = epc; v.e_qc = eqc; v.e_lat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pu, input logic [1:0] pt, input logic [15:0] pp, input logic po,
                         input logic ou, input logic [1:0] ot, input logic [1:0] om, input logic [15:0] op,
                         input logic [1:0] st);
        push = pu; push_tree = pt; push_prio = pp; pop = po; pop_out = ou;
        pop_tree = ot; pop_data = {om, op}; stat_tree = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, stat_tree);
    endtask

    task automatic do_reset();
        push = 0; pop = 0; pop_out = 0;
        arst_n = 0;
        #2;
        arst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // test 1: tree 0, pops at 2-cycle latency
        tbl[0]  = mk(1,0,5, 0,0,0,0,0, 0, 4'h0,1,1,0,0);
        tbl[1]  = mk(1,0,3, 0,0,0,0,0, 0, 4'h0,2,2,0,0);
        tbl[2]  = mk(1,0,9, 0,0,0,0,0, 0, 4'h0,3,3,0,0);
        tbl[3]  = mk(0,0,0, 1,0,0,0,0, 0, 4'h0,3,3,0,0);
        tbl[4]  = mk(0,0,0, 1,0,0,0,0, 0, 4'h0,3,3,0,0);
        tbl[5]  = mk(0,0,0, 1,1,0,0,3, 0, 4'h0,2,3,1,2);
        tbl[6]  = mk(0,0,0, 0,1,0,0,5, 0, 4'h0,1,3,2,2);
        tbl[7]  = mk(0,0,0, 0,1,0,0,9, 0, 4'h0,0,3,3,2);
        // test 2: tree 1
        tbl[8]  = mk(1,1,4, 0,0,0,0,0, 1, 4'h0,1,4,3,2);
        tbl[9]  = mk(0,0,0, 1,0,0,0,0, 1, 4'h0,1,4,3,2);
        tbl[10] = mk(0,0,0, 0,0,0,0,0, 1, 4'h0,1,4,3,2);
        tbl[11] = mk(0,0,0, 0,1,1,1,4, 1, 4'h0,0,4,4,2);
        tbl[12] = mk(1,1,2, 0,0,0,0,0, 1, 4'h0,1,5,4,2);
        tbl[13] = mk(0,0,0, 1,0,0,0,0, 1, 4'h0,1,5,4,2);
        tbl[14] = mk(0,0,0, 0,0,0,0,0, 1, 4'h0,1,5,4,2);
        tbl[15] = mk(0,0,0, 0,1,1,1,2, 1, 4'h0,0,5,5,2);
        // floor 6 lowered to 2 by a later push
        tbl[16] = mk(1,1,6, 0,0,0,0,0, 1, 4'h0,1,6,5,2);
        tbl[17] = mk(1,1,9, 0,0,0,0,0, 1, 4'h0,2,7,5,2);
        tbl[18] = mk(0,0,0, 1,0,0,0,0, 1, 4'h0,2,7,5,2);
        tbl[19] = mk(0,0,0, 1,1,1,1,6, 1, 4'h0,1,7,6,2);
        tbl[20] = mk(1,1,2, 0,0,0,0,0, 1, 4'h0,2,8,6,2);
        tbl[21] = mk(0,0,0, 1,1,1,1,2, 1, 4'h0,1,8,7,2);
        tbl[22] = mk(0,0,0, 0,1,1,1,9, 1, 4'h0,0,8,8,2);
        // simultaneous push and pop_out on tree 1: new floor = min(3,1)
        tbl[23] = mk(1,1,3, 0,0,0,0,0, 1, 4'h0,1,9,8,2);
        tbl[24] = mk(0,0,0, 1,0,0,0,0, 1, 4'h0,1,9,8,2);
        tbl[25] = mk(1,1,1, 0,1,1,1,3, 1, 4'h0,1,10,9,2);
        tbl[26] = mk(0,0,0, 1,0,0,0,0, 1, 4'h0,1,10,9,2);
        tbl[27] = mk(0,0,0, 0,1,1,1,1, 1, 4'h0,0,10,10,2);
        // test 3: order violation on tree 2
        tbl[28] = mk(1,2,7, 0,0,0,0,0, 2, 4'h0,1,11,10,2);
        tbl[29] = mk(1,2,8, 0,0,0,0,0, 2, 4'h0,2,12,10,2);
        tbl[30] = mk(0,0,0, 1,0,0,0,0, 2, 4'h0,2,12,10,2);
        tbl[31] = mk(0,0,0, 1,1,2,2,8, 2, 4'h0,1,12,11,2);
        tbl[32] = mk(0,0,0, 0,1,2,2,7, 2, 4'h1,1,12,12,2);

        #3;
        chk("rst_err", {12'h0, err}, 16'h0);
        chk("rst_push_cnt", push_cnt, 16'h0);
        chk("rst_pop_cnt", pop_cnt, 16'h0);
        chk("rst_max_lat", max_latency, 16'h0);
        chk("rst_occ", occupancy, 16'h0);
        do_reset();

        for (int i = 0; i < 33; i++) begin
            drive(tbl[i].push, tbl[i].ptree, tbl[i].pprio, tbl[i].pop, tbl[i].pout,
                  tbl[i].otree, tbl[i].ometa, tbl[i].oprio, tbl[i].stree);
            chk($sformatf("v%0d_err", i), {12'h0, err}, {12'h0, tbl[i].e_err});
            chk($sformatf("v%0d_occ", i), occupancy, tbl[i].e_occ);
            chk($sformatf("v%0d_push_cnt", i), push_cnt, tbl[i].e_pc);
            chk($sformatf("v%0d_pop_cnt", i), pop_cnt, tbl[i].e_qc);
            chk($sformatf("v%0d_max_lat", i), max_latency, tbl[i].e_lat);
        end
        chk("t3_err_tree", {14'h0, err_tree}, 16'h2);

        // test 4: underflow on empty tree 3, then tag mismatch; tree id stays frozen
        drive(0, 0, 0, 0, 1, 3, 3, 0, 3);
        chk("t4_underflow_err", {12'h0, err}, 16'h3);
        chk("t4_underflow_tree", {14'h0, err_tree}, 16'h2);
        chk("t4_pop_cnt", pop_cnt, 16'd13);
        drive(0, 0, 0, 0, 1, 1, 2, 0, 1);
        chk("t4_tag_err", {12'h0, err}, 16'h7);
        chk("t4_tag_tree", {14'h0, err_tree}, 16'h2);

        // test 5a: single outstanding pop, timeout boundary at age 65
        do_reset();
        drive(0, 2, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) drive(0, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_age64_no_err", {12'h0, err}, 16'h0);
        drive(0, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_age65_timeout", {12'h0, err}, 16'h8);
        chk("t5_timeout_tree", {14'h0, err_tree}, 16'h2);

        // test 5b: full FIFO with simultaneous pop+pop_out is legal, next pop overflows
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_full_no_err", {12'h0, err}, 16'h0);
        drive(0, 3, 0, 1, 1, 0, 0, 1, 0);
        chk("t5_full_rw_no_err", {12'h0, err}, 16'h0);
        chk("t5_full_rw_lat", max_latency, 16'd8);
        chk("t5_full_rw_occ", occupancy, 16'h0);
        drive(0, 3, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_overflow_err", {12'h0, err}, 16'h8);
        chk("t5_overflow_tree", {14'h0, err_tree}, 16'h3);

        // test 6: asynchronous reset mid-stream with two elements resident in tree 0
        drive(1, 0, 4, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 6, 1, 0, 0, 0, 0, 0);
        chk("t6_pre_occ", occupancy, 16'd2);
        push = 0; pop = 0;
        arst_n = 0;
        #1;
        chk("t6_rst_err", {12'h0, err}, 16'h0);
        chk("t6_rst_tree", {14'h0, err_tree}, 16'h0);
        chk("t6_rst_occ", occupancy, 16'h0);
        chk("t6_rst_push_cnt", push_cnt, 16'h0);
        chk("t6_rst_pop_cnt", pop_cnt, 16'h0);
        chk("t6_rst_max_lat", max_latency, 16'h0);
        #1;
        arst_n = 1;
        @(posedge clk);
        #1;
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 5, 0);
        chk("t6_post_err", {12'h0, err}, 16'h0);
        chk("t6_post_occ", occupancy, 16'h0);
        chk("t6_post_push_cnt", push_cnt, 16'h1);
        chk("t6_post_pop_cnt", pop_cnt, 16'h1);
        chk("t6_post_max_lat", max_latency, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
